// File: rtl/pkg_graybin.sv
// Shared definitions for the async FIFO and the write-port arbiter in front of it.
package pkg_graybin;

    localparam int DATASIZE  = 8;
    localparam int ARB_CNT_W = 16;

    typedef enum logic {
        ARB_IDLE,
        ARB_BURST
    } arb_state_t;

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester valid/accept bundle plus FIFO write side (idata/wren/wr_full) for the arbiter.
interface fifo_wr_arbiter_if
    import pkg_graybin::*;
#(
    parameter int NREQ = 4
) ();

    logic [NREQ-1:0]          req;
    logic [NREQ*DATASIZE-1:0] req_data;
    logic [NREQ-1:0]          gnt;
    logic [DATASIZE-1:0]      idata;
    logic                     wren;
    logic                     wr_full;

    modport master (
        input  req, req_data, wr_full,
        output gnt, idata, wren
    );

    modport slave (
        output req, req_data, wr_full,
        input  gnt, idata, wren
    );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Cyclic first-set search: lowest-distance active request at or after the pointer.
module rr_pick #(
    parameter int NREQ  = 4,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    logic [IDX_W-1:0] pos;

    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        pos   = '0;
        // Walk from the farthest candidate back to the pointer so the nearest hit wins.
        for (int k = NREQ - 1; k >= 0; k--) begin
            pos = IDX_W'((int'(ptr) + k) % NREQ);
            if (req[pos]) begin
                idx   = pos;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-bounded arbiter sharing the FIFO write port among NREQ requesters.
// Optional per-requester saturating beat counters on port beat_cnt when ARB_STATS_EN is defined.
module fifo_wr_arbiter
    import pkg_graybin::*;
#(
    parameter int NREQ      = 4,
    parameter int MAX_BURST = 4
) (
    input  logic                      wclk,
    input  logic                      wrst,
    fifo_wr_arbiter_if.master         bus,
    output logic [$clog2(NREQ)-1:0]   owner
`ifdef ARB_STATS_EN
    ,
    output logic [NREQ*ARB_CNT_W-1:0] beat_cnt
`endif
);

    localparam int         IDX_W     = $clog2(NREQ);
    localparam logic [4:0] LAST_BEAT = 5'(MAX_BURST - 1);

    arb_state_t          state_q, state_d;
    logic [IDX_W-1:0]    owner_q, owner_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [IDX_W-1:0]    pick_idx;
    logic                pick_valid;
    logic [4:0]          cnt_q, cnt_d;
    logic                hv_q;
    logic [DATASIZE-1:0] idata_q;
    logic [NREQ-1:0]     gnt_vec;
    logic                wren;
    logic                can_load;
    logic                any_gnt;
    logic [DATASIZE-1:0] slot [NREQ];

    rr_pick #(
        .NREQ (NREQ),
        .IDX_W(IDX_W)
    ) u_rr_pick (
        .req  (bus.req),
        .ptr  (ptr_q),
        .idx  (pick_idx),
        .valid(pick_valid)
    );

    // The holding stage drains whenever the FIFO has room; a new beat may refill it in the same cycle.
    assign wren      = hv_q & ~bus.wr_full;
    assign can_load  = ~hv_q | wren;
    assign bus.wren  = wren;
    assign bus.idata = idata_q;
    assign bus.gnt   = gnt_vec;
    assign owner     = owner_q;
    assign any_gnt   = |gnt_vec;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            slot[i] = bus.req_data[i*DATASIZE +: DATASIZE];
        end
    end

    always_comb begin
        gnt_vec = '0;
        if (state_q == ARB_BURST && can_load && bus.req[owner_q]) begin
            gnt_vec[owner_q] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            ARB_IDLE: begin
                if (pick_valid) begin
                    owner_d = pick_idx;
                    cnt_d   = '0;
                    state_d = ARB_BURST;
                end
            end
            ARB_BURST: begin
                // A stalled FIFO withholds gnt, so the counter simply freezes.
                if (any_gnt) begin
                    cnt_d = cnt_q + 5'd1;
                end
                if (!bus.req[owner_q] || (any_gnt && cnt_q == LAST_BEAT)) begin
                    state_d = ARB_IDLE;
                    ptr_d   = (owner_q == IDX_W'(NREQ - 1)) ? '0 : owner_q + IDX_W'(1);
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            state_q <= ARB_IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    // A beat already granted but not yet written is dropped by reset.
    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            hv_q    <= 1'b0;
            idata_q <= '0;
        end else if (any_gnt) begin
            hv_q    <= 1'b1;
            idata_q <= slot[owner_q];
        end else if (wren) begin
            hv_q    <= 1'b0;
        end
    end

`ifdef ARB_STATS_EN
    logic [ARB_CNT_W-1:0] stat_q [NREQ];

    // NOTE: this array is a handful of architectural counters, not a RAM, so clearing it on reset is intended.
    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            for (int i = 0; i < NREQ; i++) begin
                stat_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (gnt_vec[i] && stat_q[i] != '1) begin
                    stat_q[i] <= stat_q[i] + ARB_CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        beat_cnt = '0;
        for (int i = 0; i < NREQ; i++) begin
            beat_cnt[i*ARB_CNT_W +: ARB_CNT_W] = stat_q[i];
        end
    end
`endif

endmodule
